// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-side bus bundle
// for the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_ready, mem_rdata,
        input  stall, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_ready, mem_rdata,
        output stall, rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: alignment/legality check, lane steering,
// single outstanding memory access with timeout.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input logic              clk,
    input logic              reset,
    load_store_unit_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [1:0]  err_q;

    logic        legal;
    logic        aligned;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] lane;
    logic [31:0] load_d;

    always_comb begin
        legal = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !bus.req_we;
            default:                legal = 1'b0;
        endcase
    end

    always_comb begin
        aligned = 1'b1;
        be_d    = 4'b1111;
        wdata_d = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << bus.req_addr[1:0];
                wdata_d = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                aligned = !bus.req_addr[0];
                be_d    = 4'b0011 << bus.req_addr[1:0];
                wdata_d = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                aligned = (bus.req_addr[1:0] == 2'b00);
                be_d    = 4'b1111;
                wdata_d = bus.req_wdata;
            end
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend.
    always_comb begin
        lane   = bus.mem_rdata >> {off_q, 3'b000};
        load_d = bus.mem_rdata;
        case (f3_q)
            3'b000:  load_d = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_d = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_d = {24'd0, lane[7:0]};
            3'b101:  load_d = {16'd0, lane[15:0]};
            default: load_d = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            be_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (!legal) begin
                            err_q <= 2'b11;
                            state <= ERR;
                        end else if (!aligned) begin
                            err_q <= 2'b01;
                            state <= ERR;
                        end else begin
                            we_q    <= bus.req_we;
                            f3_q    <= bus.req_funct3;
                            off_q   <= bus.req_addr[1:0];
                            be_q    <= be_d;
                            addr_q  <= {bus.req_addr[31:2], 2'b00};
                            wdata_q <= wdata_d;
                            err_q   <= 2'b00;
                            cnt     <= 8'd0;
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // A ready on the final allowed cycle still completes.
                    if (bus.mem_ready) begin
                        rdata_q <= we_q ? 32'd0 : load_d;
                        state   <= RESP;
                    end else if (cnt == LAST) begin
                        err_q <= 2'b10;
                        state <= ERR;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall = reset &&
        ((state == BUSY) || (state == IDLE && bus.req_valid));
    assign bus.rsp_valid = (state == RESP) || (state == ERR);
    assign bus.rsp_rdata = (state == RESP) ? rdata_q : 32'd0;
    assign bus.rsp_err   = (state == ERR) ? err_q : 2'b00;
    assign bus.mem_req   = (state == BUSY);
    assign bus.mem_we    = (state == BUSY) && we_q;
    assign bus.mem_be    = (state == BUSY) ? be_q : 4'b0000;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning max BUSY cycles waiting for mem_ready before error (legal 2..255).
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port req_valid  in  1  core load/store request, held stable by core while stall=1.
REQ-005 SHALL have port req_we  in  1  1=store, 0=load.
REQ-006 SHALL have port req_funct3  in  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-007 SHALL have port req_addr  in  32  byte address (ALUResult).
REQ-008 SHALL have port req_wdata  in  32  store data (WriteData, unshifted).
REQ-009 SHALL have port stall  out  1  freeze core PC/regfile write.
REQ-010 SHALL have port rsp_valid  out  1  one-cycle response strobe.
REQ-011 SHALL have port rsp_rdata  out  32  load result, extended per funct3.
REQ-012 SHALL have port rsp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3; valid with rsp_valid.
REQ-013 SHALL have port mem_req  out  1  memory request.
REQ-014 SHALL have port mem_we  out  1  memory write.
REQ-015 SHALL have port mem_be  out  4  byte enables, bit i = byte lane i (little-endian).
REQ-016 SHALL have port mem_addr  out  32  word address, bits[1:0]=00.
REQ-017 SHALL have port mem_wdata  out  32  lane-replicated store data.
REQ-018 SHALL have port mem_ready  in  1  memory completes access this cycle.
REQ-019 SHALL have port mem_rdata  in  32  read word, valid when mem_ready=1.

Function
REQ-020 SHALL implement FSM states IDLE, BUSY, RESP, ERR.
REQ-021 IDLE, req_valid=1, request legal and aligned: latch request, go BUSY; stall=1 combinationally that cycle.
REQ-022 Alignment: h/hu SHALL require addr[0]=0; w SHALL require addr[1:0]=00; b/bu always aligned.
REQ-023 IDLE, req_valid=1, misaligned or illegal funct3 (or store with funct3 bu/hu/other) SHALL go ERR with no mem_req ever asserted.
REQ-024 BUSY: mem_req=1, mem_we/mem_be/mem_addr/mem_wdata SHALL remain constant from latched values until mem_ready=1.
REQ-025 mem_be: b -> 0001<<addr[1:0]; h -> 0011<<addr[1:0]; w -> 1111; loads SHALL drive same mask.
REQ-026 mem_wdata: b -> {4{wdata[7:0]}}; h -> {2{wdata[15:0]}}; w -> wdata.
REQ-027 BUSY, mem_ready=1: register extracted load data, go RESP; minimum latency request-to-rsp_valid = 2 cycles when mem_ready=1 in first BUSY cycle.
REQ-028 Load extraction: lane selected by addr[1:0]; b/h sign-extend, bu/hu zero-extend; stores SHALL return rsp_rdata=0.
REQ-029 BUSY cycle counter SHALL clear on BUSY entry and increment each BUSY cycle with mem_ready=0; on reaching TIMEOUT-1 with mem_ready=0, go ERR (rsp_err=10), drop mem_req next cycle.
REQ-030 mem_ready=1 in the same cycle as timeout SHALL complete normally (ready wins).
REQ-031 RESP: rsp_valid=1, rsp_err=00, stall=0 for exactly one cycle, then IDLE.
REQ-032 ERR: rsp_valid=1, stall=0, rsp_rdata=0 for exactly one cycle, then IDLE.
REQ-033 stall SHALL be 1 in BUSY, and in IDLE when req_valid=1; 0 otherwise.
REQ-034 Back-to-back: a new req_valid in IDLE immediately after RESP/ERR SHALL be accepted with no extra bubble.
REQ-035 mem_ready while not BUSY SHALL be ignored.
REQ-036 mem_req, mem_we, mem_be SHALL be 0 outside BUSY.

Reset
REQ-037 reset=0 SHALL immediately force IDLE, counter=0, stall/rsp_valid/mem_req/mem_we=0, mem_be=0000, rsp_rdata/rsp_err/mem_addr/mem_wdata=0.
REQ-038 reset asserted mid-BUSY SHALL abort the access with no rsp_valid; first request after release starts from IDLE.

Verification
REQ-039 lw addr=0x104, mem_rdata=0xDEADBEEF, ready in 1st BUSY cycle -> mem_addr=0x104, mem_be=1111, rsp_valid 2 cycles after request, rsp_rdata=0xDEADBEEF, rsp_err=00.
REQ-040 lb addr=0x103, mem_rdata=0x80FF0000 -> mem_be=1000, rsp_rdata=0xFFFFFF80; lbu same -> 0x00000080.
REQ-041 sh addr=0x22, wdata=0x1234ABCD -> mem_addr=0x20, mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1.
REQ-042 lw addr=0x102 -> no mem_req, rsp_valid next cycle, rsp_err=01.
REQ-043 mem_ready held 0, TIMEOUT=16 -> mem_req high 16 cycles, then rsp_err=10; ready on 16th cycle -> rsp_err=00.
REQ-044 reset=0 during 3rd BUSY cycle -> all outputs to reset values at once, no rsp_valid; next lw completes normally.
